// File: rtl/cpld_spi_responder.sv
// SPI mode-0 slave register file for the DSP link: 16-bit frames (R/nW, 7-bit addr, 8-bit data)
// over a sysclk-oversampled, synchronised SPI port.
module cpld_spi_responder (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_INV,
  output logic       spi_miso,
  input  logic [7:0] status,
  output logic [7:0] control,
  output logic       control_wr
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

  logic [1:0]  clk_sync_q, clk_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic        clk_prev_q, clk_prev_d;
  logic        cs_prev_q, cs_prev_d;
  logic [1:0]  fill_q, fill_d;
  logic        armed_q, armed_d;
  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [14:0] shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [7:0]  control_q, control_d;
  logic [7:0]  scratch_q, scratch_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;
  logic        control_wr_q, control_wr_d;

  logic        clk_rise, clk_fall, cs_fall, cs_high;
  logic [15:0] shift_in;
  logic [7:0]  rd_data;

  assign clk_rise = clk_sync_q[1] & ~clk_prev_q;
  assign clk_fall = ~clk_sync_q[1] & clk_prev_q;
  assign cs_high  = cs_sync_q[1];
  // A CS falling edge only counts once CS has been seen high through a refilled
  // synchroniser, so a reset released mid-frame cannot start a bogus frame.
  assign cs_fall  = armed_q & cs_prev_q & ~cs_sync_q[1];
  assign shift_in = {shift_q, mosi_sync_q[1]};

  always_comb begin
    unique case (shift_in[6:0])
      7'h00:   rd_data = status;
      7'h01:   rd_data = control_q;
      7'h02:   rd_data = scratch_q;
      7'h03:   rd_data = abort_cnt_q;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    clk_sync_d   = {clk_sync_q[0], spi_clk};
    mosi_sync_d  = {mosi_sync_q[0], spi_mosi};
    cs_sync_d    = {cs_sync_q[0], spi_cs_INV};
    clk_prev_d   = clk_sync_q[1];
    cs_prev_d    = cs_sync_q[1];
    fill_d       = {fill_q[0], 1'b1};
    armed_d      = armed_q | (fill_q[1] & cs_sync_q[1]);
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    miso_d       = miso_q;
    control_d    = control_q;
    scratch_d    = scratch_q;
    abort_cnt_d  = abort_cnt_q;
    control_wr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          shift_d   = '0;
          tx_d      = '0;
        end
      end
      CMD, DATA: begin
        if (cs_high) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
        end else if (clk_rise) begin
          shift_d   = shift_in[14:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (state_q == CMD && bit_cnt_q == 5'd7) begin
            state_d = DATA;
            tx_d    = shift_in[7] ? rd_data : '0;
          end else if (state_q == DATA && bit_cnt_q == 5'd15) begin
            state_d = HOLD;
            miso_d  = 1'b0;
            if (!shift_in[15]) begin
              if (shift_in[14:8] == 7'h01) begin
                control_d    = shift_in[7:0];
                control_wr_d = 1'b1;
              end else if (shift_in[14:8] == 7'h02) begin
                scratch_d = shift_in[7:0];
              end
            end
          end
        end else if (clk_fall && state_q == DATA) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      HOLD: begin
        miso_d = 1'b0;
        if (cs_high) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= '0;
      mosi_sync_q  <= '0;
      cs_sync_q    <= '1;
      clk_prev_q   <= 1'b0;
      cs_prev_q    <= 1'b1;
      fill_q       <= '0;
      armed_q      <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_q         <= '0;
      miso_q       <= 1'b0;
      control_q    <= '0;
      scratch_q    <= '0;
      abort_cnt_q  <= '0;
      control_wr_q <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_sync_q    <= cs_sync_d;
      clk_prev_q   <= clk_prev_d;
      cs_prev_q    <= cs_prev_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      control_q    <= control_d;
      scratch_q    <= scratch_d;
      abort_cnt_q  <= abort_cnt_d;
      control_wr_q <= control_wr_d;
    end
  end

  assign spi_miso   = miso_q;
  assign control    = control_q;
  assign control_wr = control_wr_q;

endmodule

// File: tb/tb_cpld_spi_responder.sv
// Directed plus randomized frames against a frame-level register-map model of the SPI responder.
module tb_cpld_spi_responder;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_cs_INV;
  logic       spi_miso;
  logic [7:0] status;
  logic [7:0] control;
  logic       control_wr;

  always #5 sysclk = ~sysclk;

  cpld_spi_responder dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_cs_INV (spi_cs_INV),
    .spi_miso   (spi_miso),
    .status     (status),
    .control    (control),
    .control_wr (control_wr)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference register map
  logic [7:0] m_control = '0;
  logic [7:0] m_scratch = '0;
  logic [7:0] m_abort   = '0;

  // control_wr pulse monitor: number of pulses and longest pulse width
  int unsigned wr_pulses  = 0;
  int unsigned wr_run     = 0;
  int unsigned wr_max_run = 0;
  always @(negedge sysclk) begin
    if (control_wr === 1'b1) begin
      wr_run = wr_run + 1;
      if (wr_run == 1) wr_pulses = wr_pulses + 1;
      if (wr_run > wr_max_run) wr_max_run = wr_run;
    end else begin
      wr_run = 0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] addr);
    case (addr)
      7'h00:   return status;
      7'h01:   return m_control;
      7'h02:   return m_scratch;
      7'h03:   return m_abort;
      default: return 8'h00;
    endcase
  endfunction

  // Drive one CS-framed burst of nbits spi_clk pulses; capture MISO just before each of the first 16 rises.
  task automatic spi_frame(input logic [15:0] word, input int nbits, input int rst_at,
                           input int chg_at, input logic [7:0] chg_val, output logic [15:0] cap);
    logic [15:0] w;
    int half;
    w    = word;
    cap  = '0;
    half = $urandom_range(4, 5);
    @(negedge sysclk);
    spi_cs_INV = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? w[15] : 1'($urandom_range(0, 1));
      w = w << 1;
      repeat (half) @(negedge sysclk);
      if (i < 16) cap = {cap[14:0], spi_miso};
      spi_clk = 1'b1;
      if (i + 1 == chg_at) status = chg_val;
      if (i + 1 == rst_at) begin
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
      end
      repeat (half) @(negedge sysclk);
      spi_clk = 1'b0;
    end
    repeat (half) @(negedge sysclk);
    spi_cs_INV = 1'b1;
    repeat (8) @(negedge sysclk);
  endtask

  task automatic run(input string tag, input logic [15:0] word, input int nbits,
                     input int rst_at, input int chg_at, input logic [7:0] chg_val);
    logic [15:0] cap;
    logic [7:0]  exp_rd;
    int unsigned pulses0;
    int unsigned exp_pulses;
    exp_rd     = word[15] ? model_read(word[14:8]) : 8'h00;
    exp_pulses = 0;
    pulses0    = wr_pulses;
    spi_frame(word, nbits, rst_at, chg_at, chg_val, cap);
    if (rst_at > 0) begin
      m_control = '0;
      m_scratch = '0;
      m_abort   = '0;
    end else if (nbits < 16) begin
      if (m_abort != 8'hFF) m_abort = m_abort + 8'd1;
    end else if (!word[15]) begin
      if (word[14:8] == 7'h01) begin
        m_control  = word[7:0];
        exp_pulses = 1;
      end else if (word[14:8] == 7'h02) begin
        m_scratch = word[7:0];
      end
    end
    if (nbits >= 16 && rst_at == 0) check({tag, " miso"}, cap, {8'h00, exp_rd});
    check({tag, " control"}, {8'h00, control}, {8'h00, m_control});
    check({tag, " wr_pulses"}, 16'(wr_pulses - pulses0), 16'(exp_pulses));
    check({tag, " miso_idle"}, {15'h0, spi_miso}, 16'h0000);
  endtask

  logic [15:0] rw;
  int          nb;

  initial begin
    reset      = 1'b1;
    spi_clk    = 1'b0;
    spi_mosi   = 1'b0;
    spi_cs_INV = 1'b1;
    status     = 8'h00;
    repeat (4) @(negedge sysclk);
    check("rst miso", {15'h0, spi_miso}, 16'h0000);
    check("rst control", {8'h00, control}, 16'h0000);
    check("rst control_wr", {15'h0, control_wr}, 16'h0000);
    reset = 1'b0;
    repeat (6) @(negedge sysclk);
    run("rst scratch", 16'h8200, 16, 0, 0, 8'h00);
    run("rst abort", 16'h8300, 16, 0, 0, 8'h00);

    run("wr ctrl A5", 16'h01A5, 16, 0, 0, 8'h00);
    run("wr scratch", 16'h023C, 16, 0, 0, 8'h00);
    run("rd scratch", 16'h8200, 16, 0, 0, 8'h00);
    run("rd 7F", 16'hFF00, 16, 0, 0, 8'h00);
    run("rd ctrl", 16'h8100, 16, 0, 0, 8'h00);

    status = 8'h5A;
    run("rd status snap", 16'h8000, 16, 0, 10, 8'hFF);

    run("abort 12", 16'h01FF, 12, 0, 0, 8'h00);
    run("rd abort 1", 16'h8300, 16, 0, 0, 8'h00);
    for (int i = 0; i < 299; i++) run("abort sat", 16'h01FF, 12, 0, 0, 8'h00);
    run("rd abort FF", 16'h8300, 16, 0, 0, 8'h00);
    run("rd abort again", 16'h8300, 16, 0, 0, 8'h00);

    run("wr 20 clocks", 16'h0142, 20, 0, 0, 8'h00);

    run("reset midframe", 16'h01AA, 16, 10, 0, 8'h00);
    run("wr after reset", 16'h0111, 16, 0, 0, 8'h00);
    run("rd abort post rst", 16'h8300, 16, 0, 0, 8'h00);

    for (int i = 0; i < 40; i++) begin
      status = 8'($urandom);
      rw[15]   = 1'($urandom_range(0, 1));
      rw[14:8] = ($urandom_range(0, 4) == 4) ? 7'($urandom) : 7'($urandom_range(0, 3));
      rw[7:0]  = 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1, 2: nb = 16;
        3:       nb = 12;
        4:       nb = 20;
        default: nb = 7;
      endcase
      run("random", rw, nb, 0, 0, 8'h00);
    end

    check("wr pulse width", 16'(wr_max_run), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpld_spi_responder.md
CPLD_SPI_RESPONDER -- requirements
Module: cpld_spi_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 sysclk  in  1  system clock, internal oscillator at 3.3-5.5 MHz.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 spi_clk  in  1  SPI clock from the DSP (mode 0, CPOL=0/CPHA=0), asynchronous to sysclk.
REQ-005 spi_mosi  in  1  SPI data from the DSP, MSB first.
REQ-006 spi_cs_INV  in  1  chip select, active low.
REQ-007 spi_miso  out  1  SPI data to the DSP, always driven and never tri-stated.
REQ-008 status  in  8  live status bits: pg/locked/state flags.
REQ-009 control  out  8  control register value.
REQ-010 control_wr  out  1  one-sysclk pulse after each write to control.

Function
REQ-011 Each input spi_clk, spi_mosi and spi_cs_INV SHALL pass through its own 2-flop synchroniser.
REQ-012 Edges SHALL be detected on the synchronised signals only; the maximum supported spi_clk is sysclk/8, so each SPI half-period is at least 4 sysclk.
REQ-013 Frame format SHALL be 16 bits, MSB first: bit15 R/nW (1 = read), bits14:8 addr[6:0], bits7:0 data.
REQ-014 Register map:
- 0x00 status (RO): snapshot of the status input.
- 0x01 control (RW).
- 0x02 scratch (RW).
- 0x03 abort_count (RO): 8-bit, saturates at 0xFF.
- All other addresses: read 0x00, writes ignored.
REQ-015 The state machine SHALL have four states: IDLE, CMD, DATA, HOLD.
REQ-016 IDLE -> CMD on the synchronised falling edge of spi_cs_INV; the 5-bit bit counter SHALL clear on entry.
REQ-017 In CMD and DATA, mosi SHALL be sampled into the shift register on each synchronised spi_clk rising edge, and the bit counter SHALL increment.
REQ-018 CMD -> DATA on the 8th rising edge.
REQ-019 At the 8th rising edge, for a read, the read data SHALL be loaded into the tx shifter; status is snapshotted at this same sysclk edge.
REQ-020 spi_miso SHALL be 0 from CS assertion through the 8th falling edge.
REQ-021 From the 8th falling edge, spi_miso SHALL present tx bit7, then shift one bit per subsequent falling edge.
REQ-022 For a write frame, spi_miso SHALL stay 0 throughout.
REQ-023 DATA -> HOLD on the 16th rising edge.
REQ-024 A write frame SHALL commit to its register in the sysclk cycle after the 16th rising edge is detected; control_wr pulses in that same cycle if addr = 0x01.
REQ-025 In HOLD, further spi_clk edges SHALL be ignored and spi_miso SHALL be 0; HOLD -> IDLE on CS deassertion.
REQ-026 CS deassertion in CMD or DATA (fewer than 16 bits) SHALL abort the frame: no register write, abort_count += 1 (saturating), return to IDLE.
REQ-027 CS deassertion SHALL take priority over a spi_clk edge detected in the same sysclk cycle.
REQ-028 In any state, spi_cs_INV high SHALL force spi_miso = 0 within one sysclk of the synchronised deassertion.
REQ-029 A read of abort_count SHALL not clear it; it wraps never.

Reset
REQ-030 While reset is asserted: state = IDLE, control = 0x00, scratch = 0x00, abort_count = 0x00, spi_miso = 0, control_wr = 0, shifters and counter = 0, synchronisers = idle values (cs high, clk low).
REQ-031 Reset asserted mid-frame SHALL discard the frame.
REQ-032 After reset release mid-frame, the block SHALL remain in IDLE until a fresh CS falling edge.

Verification
REQ-033 Write 0x01 data 0xA5 (frame 0x01A5), sysclk = 8 x spi_clk -> control = 0xA5, control_wr high for exactly 1 sysclk, spi_miso = 0 whole frame.
REQ-034 Write scratch 0x3C, then read 0x02 (frame 0x8200) -> MISO bits 7:0 = 00111100; read 0x7F -> 0x00.
REQ-035 status = 0x5A, read 0x00; change status to 0xFF after the 10th rising edge -> MISO returns 0x5A.
REQ-036 Write 0x01 0xFF with CS released after 12 bits -> control unchanged, abort_count = 0x01; 300 such aborts -> 0xFF.
REQ-037 Send 20 clocks in one write frame 0x0142 -> control = 0x42, extra bits ignored, one control_wr pulse.
REQ-038 Assert reset at bit 10 of a write, release, then send a full frame 0x0111 -> control = 0x11, no spurious write from the aborted frame.
